// File: rtl/neuron_lut_pkg.sv
// Shared constants and FSM state type for the runtime-loadable LogicNets neuron LUT.
package neuron_lut_pkg;

  localparam int DEF_IN_BITS  = 6;
  localparam int DEF_OUT_BITS = 1;
  localparam int DEF_CFG_W    = 8;

  localparam int DEPTH            = 1 << DEF_IN_BITS;
  localparam int ENTRIES_PER_BEAT = DEF_CFG_W / DEF_OUT_BITS;
  localparam int BEATS            = DEPTH / ENTRIES_PER_BEAT;

  // A single-beat table still needs a one-bit counter to stay a legal vector.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int BEAT_W = cnt_w(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } lut_state_t;

endpackage

// File: rtl/neuron_lut_ram.sv
// Distributed LUT storage: a whole configuration beat is written per cycle, one entry is read registered.
module neuron_lut_ram #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int EPB      = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [EPB*OUT_BITS-1:0] wdata,
  input  logic                    re,
  input  logic [IN_BITS-1:0]      raddr,
  output logic [OUT_BITS-1:0]     rdata
);

  localparam int DEPTH = 1 << IN_BITS;

  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; a reset would turn the LUT RAM into a bank of flops.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < EPB; i++) begin
        mem[IN_BITS'(int'(waddr) * EPB + i)] <= wdata[i*OUT_BITS +: OUT_BITS];
      end
    end
  end

  // The read register is the visible output, so it does get a reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/neuron_lut_loader.sv
// Loads a neuron truth table from packed config beats, then serves one-cycle registered lookups.
module neuron_lut_loader
  import neuron_lut_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int CFG_W    = DEF_CFG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  output logic                cfg_done,
  output logic                armed,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int EPB    = CFG_W / OUT_BITS;
  localparam int NBEATS = (1 << IN_BITS) / EPB;
  localparam int CNT_W  = cnt_w(NBEATS);

  lut_state_t       state;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat_acc;
  logic             eval_acc;

  assign in_ready = armed;
  // cfg_start wins over a coincident beat; that beat is dropped, not written.
  assign beat_acc = cfg_valid & cfg_ready & ~cfg_start;
  // Table writes only happen while unarmed, so a lookup never races a write.
  assign eval_acc = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      armed     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cfg_done  <= 1'b0;
      out_valid <= eval_acc;
      if (cfg_start) begin
        state     <= LOAD;
        beat_cnt  <= '0;
        cfg_ready <= 1'b1;
        armed     <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (beat_acc) begin
              if (beat_cnt == CNT_W'(NBEATS - 1)) begin
                state     <= ARMED;
                beat_cnt  <= '0;
                cfg_ready <= 1'b0;
                armed     <= 1'b1;
                cfg_done  <= 1'b1;
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  neuron_lut_ram #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .EPB     (EPB),
    .ADDR_W  (CNT_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (beat_acc),
    .waddr(beat_cnt),
    .wdata(cfg_data),
    .re   (eval_acc),
    .raddr(in_data),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Scoreboard bench: a reference table is built from the driven beats and each lookup is checked one cycle later.
module tb_neuron_lut_loader;
  import neuron_lut_pkg::*;

  localparam int IB = DEF_IN_BITS;
  localparam int OB = DEF_OUT_BITS;
  localparam int CW = DEF_CFG_W;

  logic          clk = 1'b0;
  logic          rst_n, cfg_start, cfg_valid, in_valid;
  logic [CW-1:0] cfg_data;
  logic [IB-1:0] in_data;
  logic          cfg_ready, cfg_done, armed, in_ready, out_valid;
  logic [OB-1:0] out_data;

  neuron_lut_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_done(cfg_done), .armed(armed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [OB-1:0] data; int due; } exp_t;
  exp_t          sb[$];
  logic [OB-1:0] model [DEPTH];
  int            bc, cyc, done_cnt, n_checks, n_errors;
  bit            m_armed, mon_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cfg_done) done_cnt++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_data", 32'(out_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end else begin
        check("out_idle", 32'(out_valid), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    m_armed = 1'b0;
    bc = 0;
  endtask

  task automatic send_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    bc = 0;
    m_armed = 1'b0;
  endtask

  task automatic send_beat(input logic [CW-1:0] d);
    check("cfg_ready_load", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_data  = d;
    tick();
    for (int j = 0; j < ENTRIES_PER_BEAT; j++) model[bc*ENTRIES_PER_BEAT + j] = d[j*OB +: OB];
    bc++;
    if (bc == BEATS) begin
      bc = 0;
      m_armed = 1'b1;
      check("cfg_done_pulse", 32'(cfg_done), 32'd1);
    end else begin
      check("cfg_done_early", 32'(cfg_done), 32'd0);
    end
  endtask

  task automatic drive_eval(input logic [IB-1:0] idx);
    exp_t e;
    in_valid = 1'b1;
    in_data  = idx;
    if (m_armed) begin
      e.data = model[idx];
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic eval_one(input logic [IB-1:0] idx);
    drive_eval(idx);
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    cyc = 0; n_checks = 0; n_errors = 0; done_cnt = 0; mon_en = 1'b0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; in_valid = 1'b0; in_data = '0;

    // Reset then idle
    do_reset(2);
    mon_en = 1'b1;
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    eval_one(6'd5);

    // Full load with cfg_valid held
    d0 = done_cnt;
    send_start();
    for (int k = 0; k < BEATS; k++) send_beat(8'hAA);
    cfg_valid = 1'b0;
    check("full_armed", 32'(armed), 32'd1);
    check("full_cfg_ready", 32'(cfg_ready), 32'd0);
    tick();
    check("full_done_once", 32'(done_cnt - d0), 32'd1);
    check("full_done_low", 32'(cfg_done), 32'd0);
    eval_one(6'd1);
    eval_one(6'd2);
    eval_one(6'd63);

    // Streaming eval 0..63 back to back
    for (int i = 0; i < DEPTH; i++) drive_eval(IB'(i));
    in_valid = 1'b0;
    tick(); tick();

    // Back-pressured load: valid toggles, data alternates FF / 00
    d0 = done_cnt;
    send_start();
    for (int i = 0; i < 2 * BEATS; i++) begin
      if (i % 2 == 0) begin
        send_beat((bc % 2 == 0) ? 8'hFF : 8'h00);
      end else begin
        cfg_valid = 1'b0;
        if (i != 2 * BEATS - 1) check("bp_not_armed", 32'(armed), 32'd0);
        tick();
      end
    end
    check("bp_armed", 32'(armed), 32'd1);
    check("bp_done_once", 32'(done_cnt - d0), 32'd1);
    eval_one(6'd3);
    eval_one(6'd8);

    // Abort mid-load then full reload
    d0 = done_cnt;
    send_start();
    for (int k = 0; k < 4; k++) send_beat(8'hFF);
    cfg_valid = 1'b0;
    send_start();
    check("abort_cfg_ready", 32'(cfg_ready), 32'd1);
    for (int k = 0; k < BEATS; k++) send_beat(8'h0F);
    cfg_valid = 1'b0;
    tick();
    check("abort_done_once", 32'(done_cnt - d0), 32'd1);
    eval_one(6'd4);
    eval_one(6'd3);
    eval_one(6'd60);

    // Reload while armed: coincident request uses the old table
    cfg_start = 1'b1;
    drive_eval(6'd1);
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    m_armed   = 1'b0;
    bc = 0;
    check("reload_armed", 32'(armed), 32'd0);
    check("reload_in_ready", 32'(in_ready), 32'd0);
    check("reload_cfg_ready", 32'(cfg_ready), 32'd1);
    eval_one(6'd1);

    // Reset mid-load, then stray beats while idle are ignored
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) send_beat(8'h55);
    cfg_valid = 1'b0;
    do_reset(1);
    check("midrst_armed", 32'(armed), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1;
    cfg_data  = 8'h33;
    repeat (BEATS + 2) tick();
    cfg_valid = 1'b0;
    check("idle_cfg_ready", 32'(cfg_ready), 32'd0);
    check("idle_armed", 32'(armed), 32'd0);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    eval_one(6'd9);

    tick(); tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
